// File: rtl/cpu7_exu_ecl_wbpipe_pkg.sv
// Shared definitions for the EXU ecl destination-tracking pipeline.
package cpu7_exu_ecl_wbpipe_pkg;

  // 32 GPRs, r0 hardwired to zero
  localparam int unsigned REG_AW_DEFAULT = 5;

  // M-stage load-data wait tracking
  typedef enum logic {
    MIdle = 1'b0,
    MWait = 1'b1
  } m_state_e;

endpackage

// File: rtl/cpu7_exu_ecl_pipereg.sv
// One pipeline stage of {valid, rd, wen, load} with hold and bubble control.
module cpu7_exu_ecl_pipereg
  import cpu7_exu_ecl_wbpipe_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              bubble,
  input  logic              valid_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              wen_in,
  input  logic              load_in,
  output logic              valid,
  output logic [REG_AW-1:0] rd,
  output logic              wen,
  output logic              load
);

  // Stage register: hold keeps everything; a bubble clears only valid and load so
  // rd/wen keep the last real instruction's attributes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      rd    <= '0;
      wen   <= 1'b0;
      load  <= 1'b0;
    end else if (!hold) begin
      if (bubble || !valid_in) begin
        valid <= 1'b0;
        load  <= 1'b0;
      end else begin
        valid <= 1'b1;
        rd    <= rd_in;
        wen   <= wen_in;
        load  <= load_in;
      end
    end
  end

endmodule

// File: rtl/cpu7_exu_ecl_wbpipe.sv
// EXU ecl destination pipeline: carries rd/wen/load from E through M to W, detects
// load-use hazards and M-stage load-data wait, and generates E/M stall control.
module cpu7_exu_ecl_wbpipe
  import cpu7_exu_ecl_wbpipe_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_exu_valid_e,
  input  logic [REG_AW-1:0] ifu_exu_rd_e,
  input  logic              ifu_exu_wen_e,
  input  logic              ifu_exu_load_e,
  input  logic [REG_AW-1:0] ifu_exu_rs1_e,
  input  logic              ifu_exu_rs1vld_e,
  input  logic [REG_AW-1:0] ifu_exu_rs2_e,
  input  logic              ifu_exu_rs2vld_e,
  input  logic              ecl_flush_e,
  input  logic              lsu_ecl_data_ok,
  output logic [REG_AW-1:0] rd_m,
  output logic [REG_AW-1:0] rd_w,
  output logic              wen_m,
  output logic              wen_w,
  output logic              valid_m,
  output logic              valid_w,
  output logic              stall_e,
  output logic              stall_m
);

  logic     wen_q_m;
  logic     load_m;
  logic     wen_q_w;
  logic     load_w;
  logic     unused_load_w;
  logic     load_held_m;
  logic     rs1_hit;
  logic     rs2_hit;
  logic     luh;
  logic     m_enter;
  m_state_e m_state;

  assign unused_load_w = load_w;

  // Hazard, stall and stage-qualification logic
  always_comb begin
    load_held_m = valid_m & load_m;
    rs1_hit     = ifu_exu_rs1vld_e & (ifu_exu_rs1_e == rd_m);
    rs2_hit     = ifu_exu_rs2vld_e & (ifu_exu_rs2_e == rd_m);
    // Load data is only available at W, so a consumer in E must wait one cycle
    luh         = ifu_exu_valid_e & load_held_m & wen_q_m & (rd_m != '0) & (rs1_hit | rs2_hit);
    // In MWait the held load is by construction still in M
    stall_m     = ~lsu_ecl_data_ok & ((m_state == MWait) | load_held_m);
    stall_e     = ~ecl_flush_e & ifu_exu_valid_e & (luh | stall_m);
    m_enter     = ifu_exu_valid_e & ~ecl_flush_e;
    wen_m       = valid_m & wen_q_m;
    wen_w       = valid_w & wen_q_w;
  end

  // M stage: holds while waiting for load data, takes a bubble on load-use interlock
  cpu7_exu_ecl_pipereg #(
    .REG_AW (REG_AW)
  ) u_stage_m (
    .clk      (clk),
    .reset    (reset),
    .hold     (stall_m),
    .bubble   (luh),
    .valid_in (m_enter),
    .rd_in    (ifu_exu_rd_e),
    .wen_in   (ifu_exu_wen_e),
    .load_in  (ifu_exu_load_e),
    .valid    (valid_m),
    .rd       (rd_m),
    .wen      (wen_q_m),
    .load     (load_m)
  );

  // W stage: never holds, receives a bubble while M is stalled
  cpu7_exu_ecl_pipereg #(
    .REG_AW (REG_AW)
  ) u_stage_w (
    .clk      (clk),
    .reset    (reset),
    .hold     (1'b0),
    .bubble   (stall_m),
    .valid_in (valid_m),
    .rd_in    (rd_m),
    .wen_in   (wen_q_m),
    .load_in  (load_m),
    .valid    (valid_w),
    .rd       (rd_w),
    .wen      (wen_q_w),
    .load     (load_w)
  );

  // M-stage load wait FSM; reset mid-load discards the outstanding load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= MIdle;
    end else begin
      unique case (m_state)
        MIdle: if (load_held_m && !lsu_ecl_data_ok) m_state <= MWait;
        MWait: if (lsu_ecl_data_ok) m_state <= MIdle;
        default: m_state <= MIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu7_exu_ecl_wbpipe.sv
// Scoreboard bench for cpu7_exu_ecl_wbpipe: directed per-cycle vectors with
// hand-computed expected outputs, checked by an independent negedge monitor.
module tb_cpu7_exu_ecl_wbpipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_e = 1'b0;
  logic [4:0] rd_e = '0;
  logic       wen_e = 1'b0;
  logic       load_e = 1'b0;
  logic [4:0] rs1_e = '0;
  logic       rs1vld_e = 1'b0;
  logic [4:0] rs2_e = '0;
  logic       rs2vld_e = 1'b0;
  logic       flush_e = 1'b0;
  logic       data_ok = 1'b0;
  logic [4:0] rd_m, rd_w;
  logic       wen_m, wen_w, valid_m, valid_w, stall_e, stall_m;

  typedef struct packed {
    logic       vm;
    logic [4:0] rdm;
    logic       wenm;
    logic       vw;
    logic [4:0] rdw;
    logic       wenw;
    logic       se;
    logic       sm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   vec_idx = 0;

  cpu7_exu_ecl_wbpipe #(
    .REG_AW (5)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ifu_exu_valid_e  (valid_e),
    .ifu_exu_rd_e     (rd_e),
    .ifu_exu_wen_e    (wen_e),
    .ifu_exu_load_e   (load_e),
    .ifu_exu_rs1_e    (rs1_e),
    .ifu_exu_rs1vld_e (rs1vld_e),
    .ifu_exu_rs2_e    (rs2_e),
    .ifu_exu_rs2vld_e (rs2vld_e),
    .ecl_flush_e      (flush_e),
    .lsu_ecl_data_ok  (data_ok),
    .rd_m             (rd_m),
    .rd_w             (rd_w),
    .wen_m            (wen_m),
    .wen_w            (wen_w),
    .valid_m          (valid_m),
    .valid_w          (valid_w),
    .stall_e          (stall_e),
    .stall_m          (stall_m)
  );

  always #5 clk = ~clk;

  // Monitor: mid-cycle, compare DUT outputs against the oldest expected entry
  always @(negedge clk) begin
    exp_t act, req;
    if (exp_q.size() > 0) begin
      req = exp_q.pop_front();
      act = '{vm: valid_m, rdm: rd_m, wenm: wen_m, vw: valid_w, rdw: rd_w, wenw: wen_w,
              se: stall_e, sm: stall_m};
      checks++;
      if (act !== req) begin
        failures++;
        $display("FAIL vec%0d got vm=%b rdm=%0d wenm=%b vw=%b rdw=%0d wenw=%b se=%b sm=%b",
                 vec_idx, act.vm, act.rdm, act.wenm, act.vw, act.rdw, act.wenw, act.se,
                 act.sm);
        $display("     vec%0d req vm=%b rdm=%0d wenm=%b vw=%b rdw=%0d wenw=%b se=%b sm=%b",
                 vec_idx, req.vm, req.rdm, req.wenm, req.vw, req.rdw, req.wenw, req.se,
                 req.sm);
      end
      vec_idx++;
    end
  end

  task automatic drv(input bit rst, input bit v, input logic [4:0] rd, input bit wen,
                     input bit ld, input logic [4:0] rs1, input bit r1v,
                     input logic [4:0] rs2, input bit r2v, input bit fl, input bit ok);
    reset    = rst;
    valid_e  = v;
    rd_e     = rd;
    wen_e    = wen;
    load_e   = ld;
    rs1_e    = rs1;
    rs1vld_e = r1v;
    rs2_e    = rs2;
    rs2vld_e = r2v;
    flush_e  = fl;
    data_ok  = ok;
  endtask

  task automatic idle(input bit ok);
    drv(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, ok);
  endtask

  // Push the expected outputs for the current cycle, then advance one cycle
  task automatic chk(input bit vm, input logic [4:0] rdm, input bit wenm, input bit vw,
                     input logic [4:0] rdw, input bit wenw, input bit se, input bit sm);
    exp_t e;
    e = '{vm: vm, rdm: rdm, wenm: wenm, vw: vw, rdw: rdw, wenw: wenw, se: se, sm: sm};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  chk(0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);                               chk(0, 0, 0, 0, 0, 0, 0, 0);
    // ALU chain: add r3; add r4 <- r3
    drv(0, 1, 3, 1, 0, 1, 1, 2, 1, 0, 0);  chk(0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 4, 1, 0, 3, 1, 0, 0, 0, 0);  chk(1, 3, 1, 0, 0, 0, 0, 0);
    idle(0);                               chk(1, 4, 1, 1, 3, 1, 0, 0);
    idle(0);                               chk(0, 4, 0, 1, 4, 1, 0, 0);
    // Load-use via rs1: ld r5; add r6 <- r5
    drv(0, 1, 5, 1, 1, 1, 1, 0, 0, 0, 0);  chk(0, 4, 0, 0, 4, 0, 0, 0);
    drv(0, 1, 6, 1, 0, 5, 1, 2, 1, 0, 1);  chk(1, 5, 1, 0, 4, 0, 1, 0);
    drv(0, 1, 6, 1, 0, 5, 1, 2, 1, 0, 0);  chk(0, 5, 0, 1, 5, 1, 0, 0);
    idle(0);                               chk(1, 6, 1, 0, 5, 0, 0, 0);
    // Load wait: data_ok low for three cycles
    drv(0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0);  chk(0, 6, 0, 1, 6, 1, 0, 0);
    idle(0);                               chk(1, 7, 1, 0, 6, 0, 0, 1);
    idle(0);                               chk(1, 7, 1, 0, 6, 0, 0, 1);
    idle(0);                               chk(1, 7, 1, 0, 6, 0, 0, 1);
    idle(1);                               chk(1, 7, 1, 0, 6, 0, 0, 0);
    idle(0);                               chk(0, 7, 0, 1, 7, 1, 0, 0);
    // Flush during stall_m: add r9 dropped, later add r10 stalls then proceeds
    drv(0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0);  chk(0, 7, 0, 0, 7, 0, 0, 0);
    drv(0, 1, 9, 1, 0, 1, 1, 0, 0, 1, 0);  chk(1, 8, 1, 0, 7, 0, 0, 1);
    drv(0, 1, 10, 1, 0, 2, 1, 0, 0, 0, 0); chk(1, 8, 1, 0, 7, 0, 1, 1);
    drv(0, 1, 10, 1, 0, 2, 1, 0, 0, 0, 1); chk(1, 8, 1, 0, 7, 0, 0, 0);
    idle(0);                               chk(1, 10, 1, 1, 8, 1, 0, 0);
    idle(0);                               chk(0, 10, 0, 1, 10, 1, 0, 0);
    // r0 destination: ld r0; add rs1=r0 -> no interlock
    drv(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);  chk(0, 10, 0, 0, 10, 0, 0, 0);
    drv(0, 1, 11, 1, 0, 0, 1, 0, 0, 0, 1); chk(1, 0, 1, 0, 10, 0, 0, 0);
    idle(0);                               chk(1, 11, 1, 1, 0, 1, 0, 0);
    idle(0);                               chk(0, 11, 0, 1, 11, 1, 0, 0);
    // Unread rs1 match is ignored; rs2 load-use interlocks
    drv(0, 1, 12, 1, 1, 0, 0, 0, 0, 0, 0);  chk(0, 11, 0, 0, 11, 0, 0, 0);
    drv(0, 1, 13, 1, 0, 12, 0, 3, 1, 0, 1); chk(1, 12, 1, 0, 11, 0, 0, 0);
    drv(0, 1, 14, 1, 0, 1, 1, 13, 1, 0, 0); chk(1, 13, 1, 1, 12, 1, 0, 0);
    drv(0, 1, 15, 1, 1, 1, 1, 0, 0, 0, 0);  chk(1, 14, 1, 1, 13, 1, 0, 0);
    drv(0, 1, 16, 1, 0, 4, 1, 15, 1, 0, 1); chk(1, 15, 1, 1, 14, 1, 1, 0);
    drv(0, 1, 16, 1, 0, 4, 1, 15, 1, 0, 0); chk(0, 15, 0, 1, 15, 1, 0, 0);
    idle(0);                                chk(1, 16, 1, 0, 15, 0, 0, 0);
    // Reset during M wait, then clean restart
    drv(0, 1, 17, 1, 1, 0, 0, 0, 0, 0, 0);  chk(0, 16, 0, 1, 16, 1, 0, 0);
    idle(0);                                chk(1, 17, 1, 0, 16, 0, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   chk(0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 18, 1, 0, 17, 1, 0, 0, 0, 0); chk(0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);                                chk(1, 18, 1, 0, 0, 0, 0, 0);
    idle(0);                                chk(0, 18, 0, 1, 18, 1, 0, 0);
    // Load without write-enable never interlocks and is not qualified as a write
    drv(0, 1, 19, 0, 1, 0, 0, 0, 0, 0, 0);  chk(0, 18, 0, 0, 18, 0, 0, 0);
    drv(0, 1, 20, 1, 0, 19, 1, 0, 0, 0, 1); chk(1, 19, 0, 0, 18, 0, 0, 0);
    idle(0);                                chk(1, 20, 1, 1, 19, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d req pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
